dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the data port of the banked Y86 memory. It shares one 32-bit read/write port between port 0 (processor memory stage) and port 1 (program loader / debug master). Each access is captured, driven onto the memory for a fixed number of cycles, and completed with a one-cycle done pulse. It sits between the requesters and the memory's `maddr`/`wenable`/`wdata`/`renable`/`rdata`/`m_ok` pins, and works with both combinational-read and clocked-read RAM.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the
// data port of the banked Y86 memory.
module dmem_arbiter #(
  parameter int unsigned READ_LAT = 0,
  parameter bit          RR       = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata_out,
  output logic        ok_out,
  output logic        busy,
  output logic        owner,
  output logic [31:0] maddr,
  output logic        wenable,
  output logic [31:0] wdata,
  output logic        renable,
  input  logic [31:0] rdata,
  input  logic        m_ok
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic [1:0] state;
  logic       last;
  logic       win;
  logic       any_req;
  logic       idle;
  logic       drv;
  acc_t       cur;
  acc_t       sel;

  assign any_req = req0 | req1;
  assign idle    = (state == IDLE);
  assign drv     = (state == ACC) || (state == WAIT);

  // On a tie, round-robin hands the slot to the port that lost last time.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 && req1):  win = RR ? ~last : 1'b0;
      (req1 && !req0): win = 1'b1;
      default:         win = 1'b0;
    endcase
  end

  always_comb begin
    sel.wr    = win ? wr1    : wr0;
    sel.addr  = win ? addr1  : addr0;
    sel.wdata = win ? wdata1 : wdata0;
  end

  assign gnt0 = reset && idle && any_req && !win;
  assign gnt1 = reset && idle && any_req && win;

  assign busy    = !idle;
  assign maddr   = drv ? cur.addr  : 32'h0;
  assign wdata   = drv ? cur.wdata : 32'h0;
  assign wenable = reset && (state == ACC) && cur.wr;
  assign renable = reset && drv && !cur.wr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata_out <= 32'h0;
      ok_out    <= 1'b0;
      cur       <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            cur   <= sel;
            owner <= win;
            last  <= win;
            state <= ACC;
          end
        end
        ACC: begin
          if (cur.wr) begin
            ok_out <= m_ok;
            done0  <= ~owner;
            done1  <= owner;
            state  <= RESP;
          end else if (READ_LAT == 0) begin
            rdata_out <= rdata;
            ok_out    <= m_ok;
            done0     <= ~owner;
            done1     <= owner;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          rdata_out <= rdata;
          ok_out    <= m_ok;
          done0     <= ~owner;
          done1     <= owner;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three dmem_arbiter instances (RR comb RAM,
// fixed-priority comb RAM, RR clocked RAM) with RAM models.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst   [3];
  logic        req0  [3];
  logic        req1  [3];
  logic        wr0   [3];
  logic        wr1   [3];
  logic [31:0] addr0 [3];
  logic [31:0] addr1 [3];
  logic [31:0] wd0   [3];
  logic [31:0] wd1   [3];
  logic        gnt0  [3];
  logic        gnt1  [3];
  logic        done0 [3];
  logic        done1 [3];
  logic [31:0] rdo   [3];
  logic        okout [3];
  logic        busy  [3];
  logic        owner [3];
  logic [31:0] maddr [3];
  logic        wen   [3];
  logic [31:0] wdat  [3];
  logic        ren   [3];
  logic [31:0] rdat  [3];
  logic        mok   [3];

  bit   [31:0] mem  [3][1024];
  bit   [31:0] rdq  [3];
  int          wcnt [3];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned RL  = (g == 2) ? 1 : 0;
    localparam bit          RRP = (g == 1) ? 1'b0 : 1'b1;

    dmem_arbiter #(.READ_LAT(RL), .RR(RRP)) u_dut (
      .clock     (clock),
      .reset     (rst[g]),
      .req0      (req0[g]),
      .req1      (req1[g]),
      .wr0       (wr0[g]),
      .wr1       (wr1[g]),
      .addr0     (addr0[g]),
      .addr1     (addr1[g]),
      .wdata0    (wd0[g]),
      .wdata1    (wd1[g]),
      .gnt0      (gnt0[g]),
      .gnt1      (gnt1[g]),
      .done0     (done0[g]),
      .done1     (done1[g]),
      .rdata_out (rdo[g]),
      .ok_out    (okout[g]),
      .busy      (busy[g]),
      .owner     (owner[g]),
      .maddr     (maddr[g]),
      .wenable   (wen[g]),
      .wdata     (wdat[g]),
      .renable   (ren[g]),
      .rdata     (rdat[g]),
      .m_ok      (mok[g])
    );

    assign mok[g]  = maddr[g] < 32'h0000_1000;
    assign rdat[g] = (RL == 1) ? rdq[g] :
                     (mok[g] ? mem[g][maddr[g][11:2]] : 32'h0);
  end

  // RAM models: out-of-range writes dropped, reads return 0
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (wen[i] && mok[i])
        mem[i][maddr[i][11:2]] <= wdat[i];
      if (wen[i])
        wcnt[i] <= wcnt[i] + 1;
      if (ren[i])
        rdq[i] <= mok[i] ? mem[i][maddr[i][11:2]] : 32'h0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return 32'hFFFF_FFF0;
    return 32'h800 + ($urandom_range(0, 63) << 2);
  endfunction

  task automatic do_access(
    input  int          i,
    input  bit          p,
    input  bit          w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output bit          gok,
    output int          lat,
    output int          wn,
    output int          rn,
    output int          bad,
    output bit          dp,
    output logic [31:0] rd,
    output logic        ok
  );
    lat = -1; wn = 0; rn = 0; bad = 0;
    dp = 1'b0; rd = 32'h0; ok = 1'b0;
    @(negedge clock);
    req0[i] = !p; req1[i] = p;
    wr0[i] = w; wr1[i] = w;
    addr0[i] = a; addr1[i] = a;
    wd0[i] = d; wd1[i] = d;
    #1;
    gok = p ? (gnt1[i] && !gnt0[i]) : (gnt0[i] && !gnt1[i]);
    @(negedge clock);
    req0[i] = 1'b0; req1[i] = 1'b0;
    addr0[i] = ~a; addr1[i] = ~a;
    wd0[i] = ~d; wd1[i] = ~d;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (wen[i]) begin
        wn++;
        if (wdat[i] !== d) bad++;
      end
      if (ren[i]) rn++;
      if ((wen[i] || ren[i]) && maddr[i] !== a) bad++;
      if (done0[i] || done1[i]) begin
        lat = c;
        dp  = done1[i];
        rd  = rdo[i];
        ok  = okout[i];
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_ties(input int i, input bit [3:0] exp_p);
    int n;
    bit gp [4];
    int gc [4];
    bit g1;
    n = 0; g1 = 1'b0;
    @(negedge clock); rst[i] = 1'b0;
    @(negedge clock); rst[i] = 1'b1;
    req0[i] = 1'b1; req1[i] = 1'b1;
    wr0[i] = 1'b1; wr1[i] = 1'b1;
    addr0[i] = 32'h300; addr1[i] = 32'h304;
    wd0[i] = 32'hAAAA_0000; wd1[i] = 32'hBBBB_1111;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (gnt1[i]) g1 = 1'b1;
      if (gnt0[i] || gnt1[i]) begin
        if (n < 4) begin
          gp[n] = gnt1[i];
          gc[n] = c;
        end
        n++;
      end
      @(negedge clock);
    end
    req0[i] = 1'b0; req1[i] = 1'b0;
    chk("ties_count", n, 4);
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        chk1("ties_port", gp[j], exp_p[j]);
        chk("ties_cycle", gc[j], 3 * j);
      end
    end
    chk1("ties_gnt1_seen", g1, |exp_p);
  endtask

  task automatic run_random(input int i, input int n);
    bit rl1, rr, act, r0, r1, win, op_p, op_w, inr;
    int k, lat_e, wn, bad;
    logic [31:0] op_a, op_d, m_rd;
    bit last;
    bit [31:0] shadow [1024];
    rl1 = (i == 2); rr = (i != 1);
    act = 1'b0; k = 0; lat_e = 0; wn = 0; bad = 0;
    op_p = 1'b0; op_w = 1'b0; op_a = 0; op_d = 0;
    @(negedge clock); rst[i] = 1'b0;
    @(negedge clock); rst[i] = 1'b1;
    last = 1'b1; m_rd = 32'h0;
    for (int c = 0; c < n + 4; c++) begin
      r0 = (c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      r1 = (c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      req0[i] = r0; req1[i] = r1;
      wr0[i] = 1'($urandom_range(0, 1));
      wr1[i] = 1'($urandom_range(0, 1));
      addr0[i] = rand_addr(); addr1[i] = rand_addr();
      wd0[i] = $urandom(); wd1[i] = $urandom();
      #1;
      if (act) begin
        k++;
        chk1("rnd_busy_gnt", gnt0[i] | gnt1[i], 1'b0);
        chk1("rnd_busy", busy[i], 1'b1);
        chk1("rnd_owner", owner[i], op_p);
        if (wen[i] || ren[i]) begin
          if (k >= lat_e || maddr[i] !== op_a) bad++;
          if (ren[i] && op_w) bad++;
        end
        if (wen[i]) begin
          wn++;
          if (wdat[i] !== op_d || !op_w) bad++;
        end
        if (k == lat_e) begin
          inr = op_a < 32'h1000;
          if (op_w) begin
            if (inr) shadow[op_a[11:2]] = op_d;
          end else begin
            m_rd = inr ? shadow[op_a[11:2]] : 32'h0;
          end
          chk1("rnd_done0", done0[i], !op_p);
          chk1("rnd_done1", done1[i], op_p);
          chk("rnd_rdata", rdo[i], m_rd);
          chk1("rnd_ok", okout[i], inr);
          chk("rnd_wen_cycles", wn, op_w ? 1 : 0);
          chk("rnd_bus_errs", bad, 0);
          act = 1'b0;
        end else begin
          chk1("rnd_early_done", done0[i] | done1[i], 1'b0);
        end
      end else begin
        win = (r0 && r1) ? (rr ? !last : 1'b0) : r1;
        chk1("rnd_gnt0", gnt0[i], (r0 | r1) && !win);
        chk1("rnd_gnt1", gnt1[i], (r0 | r1) && win);
        chk1("rnd_idle_done", done0[i] | done1[i], 1'b0);
        chk1("rnd_idle_en", wen[i] | ren[i], 1'b0);
        if (r0 || r1) begin
          act = 1'b1; k = 0; wn = 0; bad = 0;
          op_p = win; last = win;
          op_w = win ? wr1[i] : wr0[i];
          op_a = win ? addr1[i] : addr0[i];
          op_d = win ? wd1[i] : wd0[i];
          lat_e = (op_w || !rl1) ? 2 : 3;
        end
      end
      @(negedge clock);
    end
    chk1("rnd_drained", act, 1'b0);
  endtask

  typedef struct {
    int          inst;
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          wn;
    int          rn;
    logic [31:0] rd;
    bit          ok;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    bit gok, dp;
    int lat, wn, rn, bad, w0;
    logic [31:0] rd;
    logic ok;

    tbl[0] = '{0, 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 2, 1, 0, 32'h0, 1'b1};
    tbl[1] = '{0, 1'b0, 1'b0, 32'h104, 32'h0, 2, 0, 1, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{2, 1'b1, 1'b1, 32'h7, 32'h11223344, 2, 1, 0, 32'h0, 1'b1};
    tbl[3] = '{2, 1'b1, 1'b0, 32'h7, 32'h0, 3, 0, 2, 32'h11223344, 1'b1};
    tbl[4] = '{0, 1'b1, 1'b0, 32'hFFFFFFF0, 32'h0, 2, 0, 1, 32'h0, 1'b0};
    tbl[5] = '{2, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h0, 3, 0, 2, 32'h0, 1'b0};
    tbl[6] = '{1, 1'b1, 1'b1, 32'h200, 32'h0000A5A5, 2, 1, 0, 32'h0, 1'b1};
    tbl[7] = '{1, 1'b0, 1'b0, 32'h200, 32'h0, 2, 0, 1, 32'h0000A5A5, 1'b1};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; req0[i] = 1'b1; req1[i] = 1'b0;
      wr0[i] = 1'b0; wr1[i] = 1'b0;
      addr0[i] = 32'h0; addr1[i] = 32'h0;
      wd0[i] = 32'h0; wd1[i] = 32'h0;
    end

    // reset held for two cycles with port 0 requesting
    @(negedge clock);
    @(negedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1("rst_gnt0", gnt0[i], 1'b0);
      chk1("rst_busy", busy[i], 1'b0);
      chk("rst_rdata", rdo[i], 32'h0);
      chk1("rst_ok", okout[i], 1'b0);
      chk1("rst_en", wen[i] | ren[i], 1'b0);
      chk1("rst_done", done0[i] | done1[i], 1'b0);
      rst[i] = 1'b1; req0[i] = 1'b0;
    end

    for (int v = 0; v < 8; v++) begin
      do_access(tbl[v].inst, tbl[v].port, tbl[v].wr, tbl[v].addr,
                tbl[v].wdata, gok, lat, wn, rn, bad, dp, rd, ok);
      chk1($sformatf("v%0d_gnt", v), gok, 1'b1);
      chk($sformatf("v%0d_lat", v), lat, tbl[v].lat);
      chk($sformatf("v%0d_wen_cycles", v), wn, tbl[v].wn);
      chk($sformatf("v%0d_ren_cycles", v), rn, tbl[v].rn);
      chk($sformatf("v%0d_bus_errs", v), bad, 0);
      chk1($sformatf("v%0d_done_port", v), dp, tbl[v].port);
      chk($sformatf("v%0d_rdata", v), rd, tbl[v].rd);
      chk1($sformatf("v%0d_ok", v), ok, tbl[v].ok);
    end

    run_ties(0, 4'b1010);
    run_ties(1, 4'b0000);

    // reset lands in the ACC cycle of a write
    w0 = wcnt[0];
    @(negedge clock);
    req0[0] = 1'b1; wr0[0] = 1'b1;
    addr0[0] = 32'h400; wd0[0] = 32'hCAFEF00D;
    #1;
    chk1("mid_gnt0", gnt0[0], 1'b1);
    @(negedge clock);
    req0[0] = 1'b0; rst[0] = 1'b0;
    #1;
    chk1("mid_wen", wen[0], 1'b0);
    @(negedge clock);
    rst[0] = 1'b1;
    #1;
    chk1("mid_busy", busy[0], 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk1("mid_no_done", done0[0] | done1[0], 1'b0);
      chk1("mid_no_wen", wen[0], 1'b0);
      @(negedge clock);
      #1;
    end
    chk("mid_mem", mem[0][256], 32'h0);
    chk("mid_wcnt", wcnt[0], w0);

    for (int i = 0; i < 3; i++)
      run_random(i, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
